// File: rtl/instr_loader_pkg.sv
// Shared defaults, byte-count helper and FSM state type for the instruction loader.
package instr_loader_pkg;

  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_IW    = 38;

  // Bytes needed to carry one instruction word of width iw.
  function automatic int unsigned bpi_of(input int unsigned iw);
    return (iw + 32'd7) / 32'd8;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ASM  = 2'd1,
    S_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for an asynchronous push-button followed by a
// rising-edge detector; one registered pulse per press regardless of hold time.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronise, remember the previous level and emit a pulse on 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse   <= sync2_q & ~prev_q;
    end
  end

endmodule

// File: rtl/instr_loader_ram.sv
// Instruction RAM loaded MSB-first from a UART byte stream, with a
// combinational CPU fetch port and a push-button byte inspector for debug.
module instr_loader_ram
  import instr_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned IW    = DEF_IW,
  localparam int unsigned BPI  = bpi_of(IW),
  localparam int unsigned AW   = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int unsigned BW   = (BPI > 1) ? $clog2(BPI) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          clr,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] instruction,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic          load_done,
  input  logic          btn_next,
  input  logic          btn_byte,
  output logic [AW-1:0] dbg_addr,
  output logic [BW-1:0] dbg_idx,
  output logic [7:0]    dbg_byte
);

  // Previously received bytes of the word being assembled.
  localparam int unsigned SRW = (BPI > 1) ? 8 * (BPI - 1) : 8;

  state_t          state_q, state_d;
  logic [IW-1:0]   ram [DEPTH];
  logic [SRW-1:0]  sr_q;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     count_q;
  logic            full_q;
  logic            overflow_q;
  logic            load_done_q;
  logic            last_byte_c;
  logic            wr_en_c;
  logic            ovf_set_c;

  logic            next_pulse;
  logic            byte_pulse;
  logic [AW-1:0]   dbg_addr_q;
  logic [BW-1:0]   dbg_idx_q;
  logic [7:0]      dbg_byte_q;
  logic [AW:0]     dbg_lim_c;
  logic [8*BPI-1:0] dbg_word_c;
  logic [7:0]      dbg_sel_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, byte counting, write and overflow decisions.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    wr_en_c     = 1'b0;
    ovf_set_c   = 1'b0;
    last_byte_c = (byte_cnt_q == BW'(BPI - 1));
    if (clr) begin
      state_d    = S_IDLE;
      byte_cnt_d = '0;
    end else if (rx_valid) begin
      byte_cnt_d = last_byte_c ? '0 : byte_cnt_q + BW'(1);
      case (state_q)
        S_IDLE, S_ASM: begin
          if (last_byte_c) begin
            wr_en_c = 1'b1;
            state_d = (count_q == (AW+1)'(DEPTH - 1)) ? S_FULL : S_IDLE;
          end else begin
            state_d = S_ASM;
          end
        end
        S_FULL: begin
          if (last_byte_c) ovf_set_c = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Word assembly, RAM write, pointer/count and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram[AW'(i)] <= '0;
      sr_q        <= '0;
      byte_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      load_done_q <= wr_en_c;
      if (rx_valid && !clr) sr_q <= SRW'({sr_q, rx_data});
      if (wr_en_c) ram[wr_ptr_q] <= IW'({sr_q, rx_data});
      if (clr) begin
        wr_ptr_q   <= '0;
        count_q    <= '0;
        full_q     <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (wr_en_c) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          count_q  <= count_q + (AW+1)'(1);
          full_q   <= (count_q == (AW+1)'(DEPTH - 1));
        end
        if (ovf_set_c) overflow_q <= 1'b1;
      end
    end
  end

  assign instruction = ram[rd_addr];
  assign count       = count_q;
  assign full        = full_q;
  assign overflow    = overflow_q;
  assign load_done   = load_done_q;

  btn_edge u_btn_next (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_next),
    .pulse (next_pulse)
  );

  btn_edge u_btn_byte (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_byte),
    .pulse (byte_pulse)
  );

  // Highest inspectable address and the selected byte (index 0 = MSB).
  always_comb begin
    dbg_lim_c  = (count_q == '0) ? '0 : count_q - (AW+1)'(1);
    dbg_word_c = (8*BPI)'(ram[dbg_addr_q]);
    dbg_sel_c  = '0;
    for (int unsigned i = 0; i < BPI; i++) begin
      if (dbg_idx_q == BW'(i)) dbg_sel_c = dbg_word_c[8*(BPI-1-i) +: 8];
    end
  end

  // Debug cursor: saturating word address, wrapping byte index, registered byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_addr_q <= '0;
      dbg_idx_q  <= '0;
      dbg_byte_q <= '0;
    end else begin
      if (clr) begin
        dbg_addr_q <= '0;
      end else if (next_pulse && ({1'b0, dbg_addr_q} < dbg_lim_c)) begin
        dbg_addr_q <= dbg_addr_q + AW'(1);
      end
      if (byte_pulse) begin
        dbg_idx_q <= (dbg_idx_q == BW'(BPI - 1)) ? '0 : dbg_idx_q + BW'(1);
      end
      dbg_byte_q <= dbg_sel_c;
    end
  end

  assign dbg_addr = dbg_addr_q;
  assign dbg_idx  = dbg_idx_q;
  assign dbg_byte = dbg_byte_q;

endmodule

// File: tb/tb_instr_loader_ram.sv
// Randomised self-checking bench for instr_loader_ram (DEPTH=4, IW=38).
module tb_instr_loader_ram;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 38;
  localparam int unsigned BPI   = 5;
  localparam int unsigned AW    = 2;
  localparam int unsigned BW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clr;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] instruction;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
  logic          load_done;
  logic          btn_next;
  logic          btn_byte;
  logic [AW-1:0] dbg_addr;
  logic [BW-1:0] dbg_idx;
  logic [7:0]    dbg_byte;

  always #5 clk = ~clk;

  instr_loader_ram #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .clr         (clr),
    .rd_addr     (rd_addr),
    .instruction (instruction),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .load_done   (load_done),
    .btn_next    (btn_next),
    .btn_byte    (btn_byte),
    .dbg_addr    (dbg_addr),
    .dbg_idx     (dbg_idx),
    .dbg_byte    (dbg_byte)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: stored words, load count, sticky flag, pending bytes, debug cursor.
  logic [IW-1:0] m_ram [DEPTH];
  int            m_cnt;
  logic          m_ovf;
  logic [7:0]    pend [$];
  int            m_dbg_addr;
  int            m_dbg_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_dbg_byte();
    logic [39:0] w;
    w = 40'(m_ram[m_dbg_addr]);
    return w[8*(BPI-1-m_dbg_idx) +: 8];
  endfunction

  task automatic check_state(input string tag, input logic exp_ld);
    chk({tag, ".count"},     64'(count),     64'(m_cnt));
    chk({tag, ".full"},      64'(full),      64'(m_cnt == DEPTH));
    chk({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
    chk({tag, ".load_done"}, 64'(load_done), 64'(exp_ld));
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      #1;
      chk($sformatf("%s.ram[%0d]", tag, a), 64'(instruction), 64'(m_ram[a]));
    end
  endtask

  task automatic check_dbg(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, ".dbg_addr"}, 64'(dbg_addr), 64'(m_dbg_addr));
    chk({tag, ".dbg_idx"},  64'(dbg_idx),  64'(m_dbg_idx));
    chk({tag, ".dbg_byte"}, 64'(dbg_byte), 64'(m_dbg_byte()));
  endtask

  task automatic do_rst();
    rst      = 1'b1;
    rx_valid = 1'b0;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) m_ram[a] = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
    pend.delete();
    m_dbg_addr = 0;
    m_dbg_idx  = 0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic        exp_ld;
    logic [39:0] w;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    exp_ld = 1'b0;
    pend.push_back(b);
    if (pend.size() == BPI) begin
      w = '0;
      foreach (pend[i]) w = {w[31:0], pend[i]};
      if (m_cnt < DEPTH) begin
        m_ram[m_cnt] = w[IW-1:0];
        m_cnt++;
        exp_ld = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
      pend.delete();
    end
    @(negedge clk);
    check_state("byte", exp_ld);
  endtask

  task automatic do_clr(input logic with_byte, input logic [7:0] b);
    clr      = 1'b1;
    rx_valid = with_byte;
    rx_data  = b;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    rx_valid = 1'b0;
    pend.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_dbg_addr = 0;
    @(negedge clk);
    check_state("clr", 1'b0);
  endtask

  task automatic press(input logic is_next, input int hold);
    int lim;
    if (is_next) btn_next = 1'b1;
    else         btn_byte = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    btn_next = 1'b0;
    btn_byte = 1'b0;
    repeat (8) @(posedge clk);
    if (is_next) begin
      lim = (m_cnt == 0) ? 0 : m_cnt - 1;
      if (m_dbg_addr < lim) m_dbg_addr++;
    end else begin
      m_dbg_idx = (m_dbg_idx + 1) % BPI;
    end
    check_dbg(is_next ? "next" : "bsel");
  endtask

  initial begin
    logic [7:0] vec [5];
    int r;
    rx_data  = '0;
    rx_valid = 1'b0;
    clr      = 1'b0;
    rd_addr  = '0;
    btn_next = 1'b0;
    btn_byte = 1'b0;
    rst      = 1'b1;
    @(negedge clk);

    // Reset state.
    do_rst();
    check_state("rst", 1'b0);
    check_ram("rst");
    check_dbg("rst");

    // Basic word assembly.
    vec = '{8'h0A, 8'h12, 8'h34, 8'h56, 8'h78};
    foreach (vec[i]) send_byte(vec[i]);
    chk("basic.word", 64'(m_ram[0]), 64'h0A12345678);
    check_ram("basic");

    // Upper bits beyond IW discarded.
    do_clr(1'b0, 8'h00);
    vec = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    foreach (vec[i]) send_byte(vec[i]);
    chk("trunc.word", 64'(m_ram[0]), 64'h3F00000000);
    check_ram("trunc");

    // Partial word, clr, then a fresh word lands at address 0.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    do_clr(1'b0, 8'h00);
    vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (vec[i]) send_byte(vec[i]);
    check_ram("clr_mid");

    // clr coinciding with rx_valid drops the byte.
    for (int i = 0; i < 2; i++) send_byte(8'($urandom));
    do_clr(1'b1, 8'hAA);
    for (int i = 0; i < BPI; i++) send_byte(8'($urandom));
    check_ram("clr_rx");

    // Fill to full and overflow with 25 bytes.
    do_clr(1'b0, 8'h00);
    for (int i = 0; i < 25; i++) send_byte(8'($urandom));
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.ovf", 64'(overflow), 64'd1);
    check_ram("fill");

    // Debug cursor with two words loaded.
    do_clr(1'b0, 8'h00);
    for (int i = 0; i < 2 * BPI; i++) send_byte(8'($urandom));
    for (int i = 0; i < 5; i++) press(1'b1, 10);
    chk("dbg.sat", 64'(dbg_addr), 64'd1);
    for (int i = 0; i < 6; i++) press(1'b0, $urandom_range(1, 12));
    do_clr(1'b0, 8'h00);
    check_dbg("dbg_clr");

    // Reset mid-assembly discards the partial word.
    for (int i = 0; i < BPI + 2; i++) send_byte(8'($urandom));
    do_rst();
    check_state("rst2", 1'b0);
    check_ram("rst2");
    check_dbg("rst2");
    for (int i = 0; i < BPI; i++) send_byte(8'($urandom));
    check_ram("after_rst");

    // Random mix of traffic, clears, resets and button presses.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      send_byte(8'($urandom));
      else if (r < 74) do_clr(1'b0, 8'h00);
      else if (r < 78) do_clr(1'b1, 8'($urandom));
      else if (r < 87) press(1'b1, $urandom_range(1, 12));
      else if (r < 95) press(1'b0, $urandom_range(1, 12));
      else if (r < 98) begin
        check_ram("rand");
        check_dbg("rand");
      end else begin
        do_rst();
        check_state("rand_rst", 1'b0);
      end
    end
    check_ram("final");
    check_dbg("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader_ram.md
INSTR_LOADER_RAM -- requirements
Module: instr_loader_ram

Interface
REQ-001 Parameter DEPTH, default 16: number of instruction words; SHALL be a power of two, at least 2.
REQ-002 Parameter IW, default 38: instruction word width in bits, 8..64.
REQ-003 Derived constants SHALL be BPI = ceil(IW/8) bytes per instruction, AW = $clog2(DEPTH) and BW = $clog2(BPI), minimum 1.
REQ-004 clk  in  1  sole clock; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rx_data  in  8  received UART byte.
REQ-007 rx_valid  in  1  one-cycle strobe marking rx_data valid.
REQ-008 clr  in  1  synchronous load-pointer clear; RAM contents are kept.
REQ-009 rd_addr  in  AW  CPU fetch address.
REQ-010 instruction  out  IW  combinational read of ram[rd_addr]; no clock.
REQ-011 count  out  AW+1  number of words loaded.
REQ-012 full  out  1  asserted while count == DEPTH.
REQ-013 overflow  out  1  sticky; a word was dropped because the RAM was full.
REQ-014 load_done  out  1  one-cycle pulse when a word is written.
REQ-015 btn_next, btn_byte  in  1 each  asynchronous debug push-buttons.
REQ-016 dbg_addr  out  AW  word address being inspected.
REQ-017 dbg_idx  out  BW  byte index being inspected; 0 is the most significant byte.
REQ-018 dbg_byte  out  8  byte dbg_idx of ram[dbg_addr].

Function
REQ-019 Words SHALL be assembled MSB-first from BPI consecutive rx_valid bytes.
REQ-020 On the BPI-th byte, the low IW bits of the assembled value SHALL be written to ram[wr_ptr] in the same cycle; bits above IW are discarded.
REQ-021 On that write, wr_ptr and count SHALL increment and load_done SHALL pulse high in the following cycle.
REQ-022 FSM states: S_IDLE (byte_cnt=0, not full), S_ASM (0<byte_cnt<BPI), S_FULL (count==DEPTH).
- S_IDLE->S_ASM on rx_valid when BPI>1.
- S_ASM->S_IDLE on the BPI-th byte when count+1<DEPTH; S_ASM->S_FULL when count+1==DEPTH.
- S_FULL->S_IDLE only on clr or rst.
REQ-023 In S_FULL, bytes SHALL still be counted in groups of BPI; each completed group SHALL set overflow without a RAM write or a load_done pulse.
REQ-024 clr SHALL zero wr_ptr, count, byte_cnt and overflow, and SHALL move the FSM to S_IDLE.
REQ-025 If clr and rx_valid coincide, clr SHALL win and the byte SHALL be discarded.
REQ-026 A write to ram[a] SHALL be visible on instruction in the next cycle when rd_addr == a.
REQ-027 Each button SHALL pass through a two-flop synchroniser, then a rising-edge detector; each press SHALL give exactly one action regardless of hold time.
REQ-028 btn_next SHALL increment dbg_addr, saturating at max(count-1,0).
REQ-029 btn_byte SHALL increment dbg_idx, wrapping from BPI-1 to 0.
REQ-030 dbg_byte SHALL be registered, one cycle after any change of dbg_addr, dbg_idx or the RAM; byte bits above IW SHALL read as 0.
REQ-031 If clr leaves dbg_addr above the new saturation limit, dbg_addr SHALL reset to 0.

Reset
REQ-032 rst SHALL take priority over every input.
REQ-033 rst SHALL zero all RAM words, wr_ptr, count, byte_cnt, overflow, load_done, dbg_addr, dbg_idx, dbg_byte and the synchroniser flops, and SHALL set the FSM to S_IDLE.
REQ-034 rst asserted mid-assembly SHALL discard the partial word.

Structure
REQ-035 Package instr_loader_pkg SHALL hold the default DEPTH and IW, the BPI-derivation function and the state enum type.
REQ-036 Sub-module btn_edge SHALL provide the two-flop synchroniser plus rising-edge pulse; it is instantiated once per button.

Verification (DEPTH=4, IW=38, BPI=5)
REQ-037 Bytes 0A 12 34 56 78 -> ram[0]=38'h0A12345678, load_done high 1 cycle, count=1.
REQ-038 First byte FF followed by four 00 -> ram[0]=38'h3F00000000 (upper 2 bits discarded).
REQ-039 25 bytes -> count=4, full=1, overflow=1 after 25th byte, ram[0..3] hold first 20 bytes, no 5th load_done.
REQ-040 3 bytes, then clr, then 5 bytes 11 22 33 44 55 -> write lands at address 0, count=1, overflow=0.
REQ-041 count=2; btn_next 5 presses, each held 10 cycles -> dbg_addr=1; btn_byte 6 presses -> dbg_idx sequence 1,2,3,4,0,1.
REQ-042 rst after 2 bytes of the second word -> every output and every RAM word reads 0; next 5 bytes write address 0.
